imem_dmem_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read, 64x32 unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined RV32I core.
- Issues at most one access per cycle. Formats byte, half and word loads and stores, and flags misaligned data accesses.
- Blocks fetch while the core is halted by ECALL/EBREAK.
- Sits between the pipeline stage registers and the memory array.

---
 rtl/imem_dmem_arbiter_if.sv | 47 ++++
 rtl/imem_dmem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// Bundle for the fetch port, data port, halt control and unified-memory port of the arbiter.
// The master side is the core plus memory; the slave side is the arbiter.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_unsigned;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              halt;
    logic              resume;
    logic              halted;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
               halt, resume, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err, halted,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
               halt, resume, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err, halted,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one synchronous-read 64x32 memory between instruction fetch and load/store.
// Optional macro ARB_STARVE_GUARD_EN: forces a fetch grant after MAX_D_RUN contended data grants.
module imem_dmem_arbiter #(
    parameter int ADDR_W = 8
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int MAX_D_RUN = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    imem_dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_D  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_halted;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_unsigned;
    logic        r_we;
    logic        r_err;
    logic        w_if_gnt;
    logic        w_d_gnt;
    logic        w_force_if;
    logic        w_misaligned;
    logic        w_is_byte;
    logic        w_is_half;
    logic [1:0]  w_off;

    function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   fmt_load = {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   fmt_load = {{16{~uns & sh[15]}}, sh[15:0]};
            default: fmt_load = word;
        endcase
    endfunction

    assign w_off        = bus.d_addr[1:0];
    assign w_is_byte    = (bus.d_size == 2'b00);
    assign w_is_half    = (bus.d_size == 2'b01);
    assign w_misaligned = (w_is_half && w_off[0]) ||
                          (!w_is_byte && !w_is_half && (w_off != 2'b00));

`ifdef ARB_STARVE_GUARD_EN
    localparam int RUN_W = $clog2(MAX_D_RUN + 1);
    logic [RUN_W-1:0] r_d_run;

    assign w_force_if = (r_d_run == RUN_W'(MAX_D_RUN));

    // Counts data grants that made a live fetch wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_run <= '0;
        end else if (w_if_gnt) begin
            r_d_run <= '0;
        end else if (w_d_gnt && bus.if_req && !r_halted) begin
            r_d_run <= r_d_run + RUN_W'(1);
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    // Grants are suppressed while reset is held so every output reads zero.
    assign w_if_gnt   = !rst && bus.if_req && !r_halted && (!bus.d_req || w_force_if);
    assign w_d_gnt    = !rst && bus.d_req && !w_if_gnt;
    assign bus.if_gnt = w_if_gnt;
    assign bus.d_gnt  = w_d_gnt;
    assign bus.halted = r_halted;

    // Memory port driven straight from the winner; a misaligned data grant burns the slot.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0000_0000;
        if (w_if_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_be   = 4'b1111;
            bus.mem_addr = bus.if_addr[ADDR_W-1:2];
        end else if (w_d_gnt && !w_misaligned) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = bus.d_we;
            bus.mem_addr = bus.d_addr[ADDR_W-1:2];
            if (bus.d_we) begin
                case (bus.d_size)
                    2'b00: begin
                        bus.mem_be    = 4'b0001 << w_off;
                        bus.mem_wdata = {4{bus.d_wdata[7:0]}};
                    end
                    2'b01: begin
                        bus.mem_be    = 4'b0011 << w_off;
                        bus.mem_wdata = {2{bus.d_wdata[15:0]}};
                    end
                    default: begin
                        bus.mem_be    = 4'b1111;
                        bus.mem_wdata = bus.d_wdata;
                    end
                endcase
            end else begin
                bus.mem_be = 4'b1111;
            end
        end else begin
            bus.mem_en = 1'b0;
        end
    end

    // Next response owed follows this cycle's grant; response pulses decode the current state.
    always_comb begin
        w_state_nxt  = IDLE;
        bus.if_valid = 1'b0;
        bus.if_rdata = 32'h0000_0000;
        bus.d_valid  = 1'b0;
        bus.d_err    = 1'b0;
        bus.d_rdata  = 32'h0000_0000;
        if (w_if_gnt) begin
            w_state_nxt = RSP_IF;
        end else if (w_d_gnt) begin
            w_state_nxt = RSP_D;
        end else begin
            w_state_nxt = IDLE;
        end
        case (r_state)
            RSP_IF: begin
                bus.if_valid = 1'b1;
                bus.if_rdata = bus.mem_rdata;
            end
            RSP_D: begin
                bus.d_valid = 1'b1;
                bus.d_err   = r_err;
                bus.d_rdata = (r_err || r_we) ? 32'h0000_0000
                                              : fmt_load(bus.mem_rdata, r_size, r_off, r_unsigned);
            end
            default: begin
                bus.if_valid = 1'b0;
            end
        endcase
    end

    // State register and halt flag; resume beats a coincident halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.resume) begin
                r_halted <= 1'b0;
            end else if (bus.halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Data request attributes kept for formatting the response a cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size     <= 2'b00;
            r_off      <= 2'b00;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_d_gnt) begin
            r_size     <= bus.d_size;
            r_off      <= w_off;
            r_unsigned <= bus.d_unsigned;
            r_we       <= bus.d_we;
            r_err      <= w_misaligned;
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios, then random traffic against a behavioural
// model of grants, memory contents and formatted responses.
module tb_imem_dmem_arbiter;
    localparam int ADDR_W    = 8;
    localparam int MAX_D_RUN = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    imem_dmem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    bit          preload;
    bit          m_halted, exp_if_v, exp_d_v, exp_d_err, last_ig, last_dg;
    int          m_run;
    logic [31:0] exp_if_data, exp_d_data;

    // Memory array seen by the arbiter: synchronous read, byte-enabled write.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (bus.mem_en && bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle of the reference model, evaluated on the falling edge.
    task automatic tick();
        bit          e_ig, e_dg, mis;
        int          off, sz, wi;
        logic [31:0] v, be, wd, msk;
        @(negedge clk);
        if (rst) begin
            chk("rst_flags", {20'd0, bus.if_gnt, bus.if_valid, bus.d_gnt, bus.d_valid, bus.d_err,
                              bus.halted, bus.mem_en, bus.mem_we, bus.mem_be}, 32'd0);
            chk("rst_data", bus.if_rdata | bus.d_rdata | bus.mem_wdata | {26'd0, bus.mem_addr}, 32'd0);
            exp_if_v = 0; exp_d_v = 0; m_halted = 0; m_run = 0; last_ig = 0; last_dg = 0;
            return;
        end
        chk("if_valid", 32'(bus.if_valid), 32'(exp_if_v));
        if (exp_if_v) chk("if_rdata", bus.if_rdata, exp_if_data);
        chk("d_valid", 32'(bus.d_valid), 32'(exp_d_v));
        chk("d_err", 32'(bus.d_err), 32'(exp_d_v && exp_d_err));
        if (exp_d_v) chk("d_rdata", bus.d_rdata, exp_d_data);
        chk("halted", 32'(bus.halted), 32'(m_halted));

        e_dg = bus.d_req;
        e_ig = bus.if_req && !m_halted && !bus.d_req;
`ifdef ARB_STARVE_GUARD_EN
        if (bus.if_req && !m_halted && bus.d_req && m_run == MAX_D_RUN) begin
            e_ig = 1; e_dg = 0;
        end
`endif
        chk("if_gnt", 32'(bus.if_gnt), 32'(e_ig));
        chk("d_gnt", 32'(bus.d_gnt), 32'(e_dg));
        last_ig = bus.if_gnt; last_dg = bus.d_gnt;
        exp_if_v = e_ig; exp_d_v = e_dg; exp_d_err = 0; exp_d_data = 0;

        if (e_ig) begin
            wi = int'(bus.if_addr) / 4;
            exp_if_data = ref_mem[wi];
            chk("f_en", 32'(bus.mem_en), 32'd1);
            chk("f_we", 32'(bus.mem_we), 32'd0);
            chk("f_addr", 32'(bus.mem_addr), 32'(wi));
            m_run = 0;
        end else if (e_dg) begin
            off = int'(bus.d_addr) % 4;
            wi  = int'(bus.d_addr) / 4;
            sz  = (bus.d_size == 2'd3) ? 2 : int'(bus.d_size);
            mis = (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
            if (bus.if_req && !m_halted) m_run++;
            if (mis) begin
                exp_d_err = 1;
                chk("mis_en", 32'(bus.mem_en), 32'd0);
            end else begin
                chk("d_en", 32'(bus.mem_en), 32'd1);
                chk("d_we", 32'(bus.mem_we), 32'(bus.d_we));
                chk("d_addr", 32'(bus.mem_addr), 32'(wi));
                if (bus.d_we) begin
                    if (sz == 0) begin
                        be = 32'd1 << off; wd = (bus.d_wdata & 32'hFF) * 32'h0101_0101;
                    end else if (sz == 1) begin
                        be = 32'd3 << off; wd = (bus.d_wdata & 32'hFFFF) * 32'h0001_0001;
                    end else begin
                        be = 32'd15; wd = bus.d_wdata;
                    end
                    chk("st_be", 32'(bus.mem_be), be);
                    chk("st_wdata", bus.mem_wdata, wd);
                    for (int b = 0; b < 4; b++) begin
                        msk = 32'hFF << (8 * b);
                        if (be[b]) ref_mem[wi] = (ref_mem[wi] & ~msk) | (wd & msk);
                    end
                end else begin
                    chk("ld_be", 32'(bus.mem_be), 32'hF);
                    v = ref_mem[wi] >> (8 * off);
                    if (sz == 0) begin
                        v = v & 32'hFF;
                        if (!bus.d_unsigned && v >= 32'h80) v = v - 32'h100;
                    end else if (sz == 1) begin
                        v = v & 32'hFFFF;
                        if (!bus.d_unsigned && v >= 32'h8000) v = v - 32'h1_0000;
                    end
                    exp_d_data = v;
                end
            end
        end else begin
            chk("idle_en", 32'(bus.mem_en), 32'd0);
        end
        if (bus.resume) m_halted = 0;
        else if (bus.halt) m_halted = 1;
    endtask

    task automatic drive(input bit ir, input logic [7:0] ia, input bit dr, input bit we,
                         input logic [1:0] sz, input bit uns, input logic [7:0] da,
                         input logic [31:0] wd, input bit h, input bit r);
        @(posedge clk); #1;
        bus.if_req = ir; bus.if_addr = ia; bus.d_req = dr; bus.d_we = we; bus.d_size = sz;
        bus.d_unsigned = uns; bus.d_addr = da; bus.d_wdata = wd; bus.halt = h; bus.resume = r;
        tick();
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 0, 2'd0, 0, 8'h00, 32'h0, 0, 0);
    endtask

    initial begin
        int n_if;
        rst = 1'b1; preload = 1'b1;
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_size = 2'd0;
        bus.d_unsigned = 0; bus.d_addr = '0; bus.d_wdata = 32'h0; bus.halt = 0; bus.resume = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        ref_mem[0] = 32'h0000_0073; ref_mem[1] = 32'h0010_0073;
        ref_mem[2] = 32'h0000_000F; ref_mem[4] = 32'h0040_0293;
        tick();
        @(posedge clk); #1; tick();
        @(posedge clk); #1; rst = 1'b0; preload = 1'b0; tick();

        // fetch stream, one word per cycle
        drive(1, 8'h00, 0, 0, 2'd0, 0, 8'h00, 32'h0, 0, 0);
        drive(1, 8'h04, 0, 0, 2'd0, 0, 8'h00, 32'h0, 0, 0);
        drive(1, 8'h08, 0, 0, 2'd0, 0, 8'h00, 32'h0, 0, 0);
        idle();
        chk("fetch_word2", bus.if_rdata, 32'h0000_000F);

        // contention: load wins, fetch follows
        drive(1, 8'h0C, 1, 0, 2'd2, 0, 8'h10, 32'h0, 0, 0);
        drive(1, 8'h0C, 0, 0, 2'd2, 0, 8'h10, 32'h0, 0, 0);
        chk("contend_ld", bus.d_rdata, 32'h0040_0293);
        idle();

        // byte store then signed and unsigned byte loads
        drive(0, 8'h00, 1, 1, 2'd0, 0, 8'h02, 32'h0000_0080, 0, 0);
        chk("sb_be", 32'(bus.mem_be), 32'b0100);
        chk("sb_wdata", bus.mem_wdata, 32'h8080_8080);
        drive(0, 8'h00, 1, 0, 2'd0, 0, 8'h02, 32'h0, 0, 0);
        idle();
        chk("lb", bus.d_rdata, 32'hFFFF_FF80);
        drive(0, 8'h00, 1, 0, 2'd0, 1, 8'h02, 32'h0, 0, 0);
        idle();
        chk("lbu", bus.d_rdata, 32'h0000_0080);

        // misaligned word load
        drive(1, 8'h00, 1, 0, 2'd2, 0, 8'h06, 32'h0, 0, 0);
        chk("mis_mem_en", 32'(bus.mem_en), 32'd0);
        drive(0, 8'h00, 0, 0, 2'd0, 0, 8'h00, 32'h0, 0, 0);
        chk("mis_err", 32'(bus.d_err), 32'd1);

        // halt blocks fetch but not a store; resume reopens fetch
        drive(0, 8'h00, 0, 0, 2'd0, 0, 8'h00, 32'h0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 8'h10, k == 2, 1, 2'd2, 0, 8'h20, 32'hCAFE_F00D, 0, 0);
            chk("halt_if_gnt", 32'(bus.if_gnt), 32'd0);
            chk("halt_flag", 32'(bus.halted), 32'd1);
        end
        drive(1, 8'h10, 0, 0, 2'd0, 0, 8'h00, 32'h0, 0, 1);
        drive(1, 8'h10, 0, 0, 2'd0, 0, 8'h00, 32'h0, 0, 0);
        chk("resume_if_gnt", 32'(bus.if_gnt), 32'd1);
        idle();
        drive(0, 8'h00, 0, 0, 2'd0, 0, 8'h00, 32'h0, 1, 1);
        drive(1, 8'h20, 0, 0, 2'd0, 0, 8'h00, 32'h0, 0, 0);
        chk("halt_resume_same", 32'(bus.if_gnt), 32'd1);
        idle();

        // reset right after a load grant drops the response
        drive(0, 8'h00, 1, 0, 2'd2, 0, 8'h10, 32'h0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.d_req = 0;
        tick();
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        preload = 1'b1;
        @(posedge clk); #1; tick();
        @(posedge clk); #1; rst = 1'b0; preload = 1'b0; tick();

`ifdef ARB_STARVE_GUARD_EN
        n_if = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 8'h04, 1, 0, 2'd2, 0, 8'h10, 32'h0, 0, 0);
            if (bus.if_gnt) n_if++;
        end
        chk("starve_if_grants", 32'(n_if), 32'd2);
        idle();
`else
        n_if = 0;
`endif

        // random traffic; requests held until granted
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!bus.if_req || last_ig) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = 8'($urandom);
            end
            if (!bus.d_req || last_dg) begin
                bus.d_req      = ($urandom_range(0, 2) == 0);
                bus.d_we       = $urandom_range(0, 1) == 1;
                bus.d_size     = 2'($urandom_range(0, 3));
                bus.d_unsigned = $urandom_range(0, 1) == 1;
                bus.d_addr     = 8'($urandom);
                bus.d_wdata    = $urandom;
            end
            bus.halt   = ($urandom_range(0, 39) == 0);
            bus.resume = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
